bf_execute: RTL
===============

Name: bf_execute

Overview:
- Execute stage of the 8-bit Brainfuck core; sits directly downstream of the fetch stage.
- Consumes the fetched instruction byte and the PC it came from, then performs the operation.
- Operations touch the data pointer, tape memory, I/O, and a bracket return stack.
- Produces next_pc and exec_ready back to the sequencer, which then re-enables fetch.

Parameters:
STACK_DEPTH, 8, number of '[' return addresses held (nesting limit); sp width = clog2(STACK_DEPTH)+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
exec_en  input  1  level request from sequencer; held high until exec_ready seen, then dropped >=1 cycle
inst  input  8  instruction byte from fetch (sampled at accept)
pc  input  8  address of inst (sampled at accept)
next_pc  output  8  PC for next fetch, valid while exec_ready=1
exec_ready  output  1  instruction complete
dp  output  8  data pointer
mem_addr  output  8  tape address (registered, always = dp)
mem_rdata  input  8  tape read data, sync memory
mem_wdata  output  8  tape write data
mem_we  output  1  tape write strobe, one-cycle pulse
prog_addr  output  8  program-memory scan address
prog_rdata  input  8  program-memory read data, sync
out_data  output  8  '.' output byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
in_data  input  8  ',' input byte
in_valid  input  1  in_data valid (one-cycle consume)
err  output  1  sticky fault flag: stack over/underflow or unmatched '['

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; dp=0, sp=0.
  - All outputs 0, except mem_addr which stays 0 because it tracks dp.
  - err cleared only by reset.
- Memory timing (both memories):
  - Address registered at edge N; read data sampled at edge N+2.
  - Sequence is addr, wait, capture.
- Accept: at edge 0, state=IDLE and exec_en=1 latch inst/pc.
- Completion:
  - Completes by setting exec_ready=1 and next_pc; both held.
  - An accepted instruction always completes, even if exec_en drops.
  - Once exec_en is sampled low with exec_ready=1: clear exec_ready, go to IDLE.
- Decode:
  - '>' 0x3E: dp+1, wraps 0xFF->0x00.
  - '<' 0x3C: dp-1, wraps 0x00->0xFF.
  - Both: next_pc=pc+1, exec_ready at edge 1, no memory access.
- '+' 0x2B / '-' 0x2D:
  - Read cell (capture at edge 2).
  - mem_wdata = cell±1 mod 256; mem_we=1 for the single cycle after edge 3.
  - exec_ready at edge 4.
- '.' 0x2E:
  - Read cell; out_data=cell, out_valid=1 from edge 3.
  - Hold until out_ready sampled high; on that edge out_valid=0 and exec_ready=1.
- ',' 0x2C:
  - Wait in IN state until in_valid=1.
  - Then mem_wdata=in_data with a one-cycle mem_we pulse; exec_ready on the following edge.
- '[' 0x5B, read cell:
  - Cell nonzero: push pc; next_pc=pc+1; exec_ready at edge 3.
  - Stack full: no push, err=1, next_pc=pc+1.
  - Cell zero: forward scan. depth=1, prog_addr=pc+1.
    - Each byte costs 3 cycles (ADDR, WAIT, CHK).
    - '[' raises depth; ']' lowers it.
    - When depth reaches 0 at address a: next_pc=a+1.
    - If prog_addr wraps around to equal pc before a match: err=1, next_pc=pc+1.
- ']' 0x5D, read cell:
  - Cell nonzero: next_pc=stack[top]+1, stack unchanged.
  - Cell zero: pop, next_pc=pc+1.
  - Either case: exec_ready at edge 3.
  - Stack empty: err=1, next_pc=pc+1, no pop.
- Any other byte: NOP, next_pc=pc+1, exec_ready at edge 1.
- Arithmetic: all PC/dp/cell arithmetic is 8-bit modulo 256; next_pc=0xFF+1 gives 0x00.
- rst mid-operation:
  - Immediate return to IDLE.
  - mem_we and out_valid drop combinationally with reset; no partial write is completed.

Test Plan:
- '>' with dp=0xFF, pc=0x10 -> dp=0x00, next_pc=0x11, exec_ready at edge 1, mem_we never asserted.
- '+' with cell[0x05]=0xFF, dp=0x05 -> single mem_we pulse at cycle after edge 3, mem_wdata=0x00, exec_ready edge 4.
- '.' with cell=0x41, out_ready held low 5 cycles then high -> out_data=0x41, out_valid high 5+ cycles, exec_ready the edge after out_ready sampled.
- Program "[[-]]+" at 0x00, cell=0, '[' at pc=0x00 -> scan visits 0x01..0x04, next_pc=0x05, sp unchanged, err=0.
- Loop: '[' at pc=0x20, cell=2, then ']' at pc=0x22 with cell=1 -> next_pc=0x21; then ']' with cell=0 -> next_pc=0x23, sp=0.
- ']' with empty stack -> err=1, next_pc=pc+1; STACK_DEPTH+1 nested '[' with nonzero cell -> err=1 on last; assert rst during '+' wait -> mem_we never pulses, state IDLE, dp=0.

Source files
------------

// File: rtl/bf_execute_if.sv
// rtl/bf_execute_if.sv - sequencer <-> execute stage handshake bundle
interface bf_execute_if;
  logic       exec_en;
  logic [7:0] inst;
  logic [7:0] pc;
  logic [7:0] next_pc;
  logic       exec_ready;

  modport master (output exec_en, output inst, output pc, input next_pc, input exec_ready);
  modport slave  (input exec_en, input inst, input pc, output next_pc, output exec_ready);
endinterface

// File: rtl/bf_execute.sv
// rtl/bf_execute.sv - execute stage of the 8-bit Brainfuck core
module bf_execute #(
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  bf_execute_if.slave ex,
  output logic [7:0]  dp,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [7:0]  prog_addr,
  input  logic [7:0]  prog_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        err
);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_JZ    = 8'h5B;
  localparam logic [7:0] OP_JNZ   = 8'h5D;

  // S_RD waits out the memory latency; the cell is captured when leaving it.
  // The forward scan cycles S_SADDR -> S_SWAIT -> S_SCHK per program byte.
  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_RD, S_ALU, S_WR, S_OUT, S_IN,
    S_SWAIT, S_SCHK, S_SADDR, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] inst_q, inst_d, pc_q, pc_d, dp_q, dp_d, cell_q, cell_d;
  logic [7:0] next_pc_q, next_pc_d, wdata_q, wdata_d, paddr_q, paddr_d;
  logic [7:0] out_data_q, out_data_d, depth_q, depth_d;
  logic       ready_q, ready_d, we_q, we_d, oval_q, oval_d, err_q, err_d;
  logic [SPW-1:0] sp_q, sp_d, sp_top;
  logic       push, fin;
  logic [7:0] fin_pc;
  logic [7:0] stack_mem [STACK_DEPTH];

  assign sp_top = sp_q - SPW'(1);

  // Next-state and next-register computation; fin collapses every completion path.
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    dp_d       = dp_q;
    cell_d     = cell_q;
    next_pc_d  = next_pc_q;
    ready_d    = ready_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    paddr_d    = paddr_q;
    out_data_d = out_data_q;
    oval_d     = oval_q;
    err_d      = err_q;
    sp_d       = sp_q;
    depth_d    = depth_q;
    push       = 1'b0;
    fin        = 1'b0;
    fin_pc     = pc_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (ex.exec_en) begin
          inst_d  = ex.inst;
          pc_d    = ex.pc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (inst_q)
          OP_RIGHT: begin dp_d = dp_q + 8'd1; fin = 1'b1; end
          OP_LEFT:  begin dp_d = dp_q - 8'd1; fin = 1'b1; end
          OP_INC, OP_DEC, OP_OUT, OP_JZ, OP_JNZ: state_d = S_RD;
          OP_IN:    state_d = S_IN;
          default:  fin = 1'b1;
        endcase
      end
      S_RD: begin
        cell_d  = mem_rdata;
        state_d = S_ALU;
      end
      S_ALU: begin
        case (inst_q)
          OP_INC: begin wdata_d = cell_q + 8'd1; we_d = 1'b1; state_d = S_WR; end
          OP_DEC: begin wdata_d = cell_q - 8'd1; we_d = 1'b1; state_d = S_WR; end
          OP_OUT: begin out_data_d = cell_q; oval_d = 1'b1; state_d = S_OUT; end
          OP_JZ: begin
            if (cell_q != 8'd0) begin
              if (sp_q == SPW'(STACK_DEPTH)) begin
                err_d = 1'b1;
              end else begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
              end
              fin = 1'b1;
            end else begin
              depth_d = 8'd1;
              paddr_d = pc_q + 8'd1;
              state_d = S_SWAIT;
            end
          end
          OP_JNZ: begin
            fin = 1'b1;
            if (sp_q == '0) begin
              err_d = 1'b1;
            end else if (cell_q != 8'd0) begin
              fin_pc = stack_mem[sp_top[AW-1:0]] + 8'd1;
            end else begin
              sp_d = sp_top;
            end
          end
          default: fin = 1'b1;
        endcase
      end
      S_WR: fin = 1'b1;
      S_OUT: begin
        if (out_ready) begin
          oval_d = 1'b0;
          fin    = 1'b1;
        end
      end
      S_IN: begin
        if (in_valid) begin
          wdata_d = in_data;
          we_d    = 1'b1;
          state_d = S_WR;
        end
      end
      S_SWAIT: state_d = S_SCHK;
      S_SCHK: begin
        if (prog_rdata == OP_JZ) begin
          depth_d = depth_q + 8'd1;
          state_d = S_SADDR;
        end else if (prog_rdata == OP_JNZ && depth_q == 8'd1) begin
          fin_pc = paddr_q + 8'd1;
          fin    = 1'b1;
        end else begin
          if (prog_rdata == OP_JNZ) depth_d = depth_q - 8'd1;
          state_d = S_SADDR;
        end
      end
      S_SADDR: begin
        if (paddr_q + 8'd1 == pc_q) begin
          err_d = 1'b1;
          fin   = 1'b1;
        end else begin
          paddr_d = paddr_q + 8'd1;
          state_d = S_SWAIT;
        end
      end
      S_DONE: begin
        if (!ex.exec_en) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      next_pc_d = fin_pc;
      ready_d   = 1'b1;
      state_d   = S_DONE;
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inst_q     <= 8'd0;
      pc_q       <= 8'd0;
      dp_q       <= 8'd0;
      cell_q     <= 8'd0;
      next_pc_q  <= 8'd0;
      ready_q    <= 1'b0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      paddr_q    <= 8'd0;
      out_data_q <= 8'd0;
      oval_q     <= 1'b0;
      err_q      <= 1'b0;
      sp_q       <= '0;
      depth_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      dp_q       <= dp_d;
      cell_q     <= cell_d;
      next_pc_q  <= next_pc_d;
      ready_q    <= ready_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      paddr_q    <= paddr_d;
      out_data_q <= out_data_d;
      oval_q     <= oval_d;
      err_q      <= err_d;
      sp_q       <= sp_d;
      depth_q    <= depth_d;
    end
  end

  // Return-address storage; contents are only meaningful below sp, so no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp_q[AW-1:0]] <= pc_q;
  end

  assign ex.next_pc    = next_pc_q;
  assign ex.exec_ready = ready_q;
  assign dp            = dp_q;
  assign mem_addr      = dp_q;
  assign mem_wdata     = wdata_q;
  assign mem_we        = we_q & ~rst;
  assign prog_addr     = paddr_q;
  assign out_data      = out_data_q;
  assign out_valid     = oval_q & ~rst;
  assign err           = err_q;
endmodule
